// File: rtl/mult_pipe_array.sv
// Array of independent RV32M multiply lanes. Each lane is a LATENCY-deep pipeline
// that stalls as a whole while its output register waits for the CDB arbiter.
module mult_pipe_array #(
    parameter int NUM_LANES = 2,
    parameter int XLEN      = 32,
    parameter int LATENCY   = 3,
    parameter int TAG_W     = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       branch_mispredict,
    input  logic [NUM_LANES-1:0]       fu_start,
    input  logic [2*NUM_LANES-1:0]     op,
    input  logic [XLEN*NUM_LANES-1:0]  rs1_val,
    input  logic [XLEN*NUM_LANES-1:0]  rs2_val,
    input  logic [TAG_W*NUM_LANES-1:0] tag_in,
    input  logic [NUM_LANES-1:0]       cdb_ack,
    output logic [NUM_LANES-1:0]       fu_busy,
    output logic [NUM_LANES-1:0]       fu_done,
    output logic [XLEN*NUM_LANES-1:0]  result,
    output logic [TAG_W*NUM_LANES-1:0] result_tag
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [1:0]        lane_op;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic              a_sign;
        logic              b_sign;
        logic [2*XLEN-1:0] a_ext;
        logic [2*XLEN-1:0] b_ext;
        logic [2*XLEN-1:0] product;
        logic [XLEN-1:0]   product_sel;
        logic              advance;
        logic              accept;

        assign lane_op = op[2*l +: 2];
        assign a       = rs1_val[l*XLEN +: XLEN];
        assign b       = rs2_val[l*XLEN +: XLEN];

        always_comb begin
            a_sign = 1'b0;
            b_sign = 1'b0;
            case (lane_op)
                OP_MULH: begin
                    a_sign = a[XLEN-1];
                    b_sign = b[XLEN-1];
                end
                OP_MULHSU: a_sign = a[XLEN-1];
                default: ;
            endcase
        end

        // The low 2*XLEN bits of the 33x33 signed product equal a 2*XLEN-wide
        // product of the sign/zero-extended operands, which is all we ever select.
        assign a_ext       = {{XLEN{a_sign}}, a};
        assign b_ext       = {{XLEN{b_sign}}, b};
        assign product     = a_ext * b_ext;
        assign product_sel = (lane_op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

        assign advance = ~g_stage[LATENCY-1].valid_q | cdb_ack[l];
        assign accept  = fu_start[l] & advance;

        for (genvar s = 0; s < LATENCY; s++) begin : g_stage
            logic             valid_q;
            logic [XLEN-1:0]  data_q;
            logic [TAG_W-1:0] tag_q;
            logic             load_valid;
            logic [XLEN-1:0]  load_data;
            logic [TAG_W-1:0] load_tag;

            if (s == 0) begin : g_head
                assign load_valid = accept;
                assign load_data  = product_sel;
                assign load_tag   = tag_in[l*TAG_W +: TAG_W];
            end else begin : g_body
                assign load_valid = g_stage[s-1].valid_q;
                assign load_data  = g_stage[s-1].data_q;
                assign load_tag   = g_stage[s-1].tag_q;
            end

            // Payload only moves with a valid op so the output register keeps its last result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    tag_q   <= '0;
                end else if (branch_mispredict) begin
                    valid_q <= 1'b0;
                end else if (advance) begin
                    valid_q <= load_valid;
                    if (load_valid) begin
                        data_q <= load_data;
                        tag_q  <= load_tag;
                    end
                end
            end
        end

        assign fu_done[l]                   = g_stage[LATENCY-1].valid_q;
        assign fu_busy[l]                   = ~advance;
        assign result[l*XLEN +: XLEN]       = g_stage[LATENCY-1].data_q;
        assign result_tag[l*TAG_W +: TAG_W] = g_stage[LATENCY-1].tag_q;
    end

endmodule
